// File: rtl/multi_ch_blink_gen.sv
// Multi-channel blink/pulse/PWM generator: one shared prescaler tick drives
// NUM_CH independent period counters, each configurable at run time.
module multi_ch_blink_gen #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [PRESC_W-1:0] i_presc_th,
  input  logic               i_cfg_valid,
  input  logic [CH_W-1:0]    i_cfg_ch,
  input  logic [1:0]         i_cfg_mode,
  input  logic [CNT_W-1:0]   i_cfg_period,
  input  logic [CNT_W-1:0]   i_cfg_duty,
  output logic [NUM_CH-1:0]  o_out,
  output logic [NUM_CH-1:0]  o_wrap
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_TOGGLE = 2'd1,
    MODE_PULSE  = 2'd2,
    MODE_PWM    = 2'd3
  } mode_t;

  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

  logic [PRESC_W-1:0] presc_cnt;
  logic [PRESC_W-1:0] th_m1;
  logic               tick;

  mode_t            mode_q   [NUM_CH];
  logic [CNT_W-1:0] period_q [NUM_CH];
  logic [CNT_W-1:0] duty_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_q    [NUM_CH];
  logic [CNT_W-1:0] cnt_nxt  [NUM_CH];
  logic [CNT_W-1:0] per_m1   [NUM_CH];
  logic [NUM_CH-1:0] wrap_c;
  logic [NUM_CH-1:0] cfg_hit;

  // Using >= also recovers immediately when the threshold is lowered below the count.
  always_comb begin
    th_m1 = (i_presc_th == '0) ? '0 : (i_presc_th - PRESC_ONE);
    tick  = enable && (presc_cnt >= th_m1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_cnt <= '0;
    end else if (!enable || tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PRESC_ONE;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      per_m1[c]  = (period_q[c] == '0) ? '0 : (period_q[c] - CNT_ONE);
      wrap_c[c]  = tick && (mode_q[c] != MODE_OFF) && (cnt_q[c] >= per_m1[c]);
      cnt_nxt[c] = cnt_q[c];
      if (wrap_c[c]) begin
        cnt_nxt[c] = '0;
      end else if (tick && (mode_q[c] != MODE_OFF)) begin
        cnt_nxt[c] = cnt_q[c] + CNT_ONE;
      end
      cfg_hit[c] = i_cfg_valid && (i_cfg_ch == CH_W'(c));
    end
  end

  // Config loads even while disabled; enable=0 and config writes both restart the counter.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!reset_n) begin
        mode_q[c]   <= MODE_OFF;
        period_q[c] <= '0;
        duty_q[c]   <= '0;
        cnt_q[c]    <= '0;
        o_out[c]    <= 1'b0;
        o_wrap[c]   <= 1'b0;
      end else begin
        if (cfg_hit[c]) begin
          mode_q[c]   <= mode_t'(i_cfg_mode);
          period_q[c] <= i_cfg_period;
          duty_q[c]   <= i_cfg_duty;
        end
        if (!enable || cfg_hit[c]) begin
          cnt_q[c]  <= '0;
          o_out[c]  <= 1'b0;
          o_wrap[c] <= 1'b0;
        end else begin
          cnt_q[c]  <= cnt_nxt[c];
          o_wrap[c] <= wrap_c[c];
          case (mode_q[c])
            MODE_TOGGLE: o_out[c] <= o_out[c] ^ wrap_c[c];
            MODE_PULSE:  o_out[c] <= wrap_c[c];
            MODE_PWM:    o_out[c] <= (cnt_nxt[c] < duty_q[c]);
            default:     o_out[c] <= 1'b0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_ch_blink_gen.sv
// Directed bench for multi_ch_blink_gen with three channels so that an
// out-of-range channel index (3) is representable.
module tb_multi_ch_blink_gen;

  localparam int NUM_CH  = 3;
  localparam int CNT_W   = 16;
  localparam int PRESC_W = 8;
  localparam int CH_W    = 2;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               enable;
  logic [PRESC_W-1:0] i_presc_th;
  logic               i_cfg_valid;
  logic [CH_W-1:0]    i_cfg_ch;
  logic [1:0]         i_cfg_mode;
  logic [CNT_W-1:0]   i_cfg_period;
  logic [CNT_W-1:0]   i_cfg_duty;
  logic [NUM_CH-1:0]  o_out;
  logic [NUM_CH-1:0]  o_wrap;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multi_ch_blink_gen #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .PRESC_W(PRESC_W),
    .CH_W   (CH_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .i_presc_th  (i_presc_th),
    .i_cfg_valid (i_cfg_valid),
    .i_cfg_ch    (i_cfg_ch),
    .i_cfg_mode  (i_cfg_mode),
    .i_cfg_period(i_cfg_period),
    .i_cfg_duty  (i_cfg_duty),
    .o_out       (o_out),
    .o_wrap      (o_wrap)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [CH_W-1:0] ch, input logic [1:0] mode,
                           input logic [CNT_W-1:0] per, input logic [CNT_W-1:0] duty);
    i_cfg_valid  = 1'b1;
    i_cfg_ch     = ch;
    i_cfg_mode   = mode;
    i_cfg_period = per;
    i_cfg_duty   = duty;
    step();
    i_cfg_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b1;
    i_presc_th = 8'd1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (o_out !== 3'b000) begin
      errors++;
      $display("FAIL reset_out got=%b exp=%b", o_out, 3'b000);
    end
    checks++;
    if (o_wrap !== 3'b000) begin
      errors++;
      $display("FAIL reset_wrap got=%b exp=%b", o_wrap, 3'b000);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_toggle();
    logic eo, ew;
    cfg_write(2'd0, 2'd1, 16'd3, 16'd0);
    checks++;
    if (o_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL toggle_after_write got=%b exp=0", o_out[0]);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      eo = ((k / 3) % 2) == 1;
      ew = (k % 3) == 0;
      checks++;
      if (o_out[0] !== eo) begin
        errors++;
        $display("FAIL toggle_out k=%0d got=%b exp=%b", k, o_out[0], eo);
      end
      checks++;
      if (o_wrap[0] !== ew) begin
        errors++;
        $display("FAIL toggle_wrap k=%0d got=%b exp=%b", k, o_wrap[0], ew);
      end
    end
  endtask

  task automatic test_prescaler_pulse();
    logic e;
    i_presc_th = 8'd4;
    cfg_write(2'd1, 2'd2, 16'd2, 16'd0);
    // Ticks land on edges 3,7,11,... after the write; the second tick of each pair wraps.
    for (int k = 1; k <= 24; k++) begin
      step();
      e = (k % 8) == 7;
      checks++;
      if (o_out[1] !== e) begin
        errors++;
        $display("FAIL presc4_pulse k=%0d got=%b exp=%b", k, o_out[1], e);
      end
      checks++;
      if (o_wrap[1] !== e) begin
        errors++;
        $display("FAIL presc4_wrap k=%0d got=%b exp=%b", k, o_wrap[1], e);
      end
    end
    i_presc_th = 8'd0;
    for (int m = 1; m <= 8; m++) begin
      step();
      e = (m % 2) == 0;
      checks++;
      if (o_out[1] !== e) begin
        errors++;
        $display("FAIL presc0_pulse m=%0d got=%b exp=%b", m, o_out[1], e);
      end
    end
    i_presc_th = 8'd1;
  endtask

  task automatic test_pwm();
    logic eo, ew;
    cfg_write(2'd2, 2'd3, 16'd10, 16'd3);
    checks++;
    if (o_out[2] !== 1'b0) begin
      errors++;
      $display("FAIL pwm_after_write got=%b exp=0", o_out[2]);
    end
    for (int k = 1; k <= 20; k++) begin
      step();
      eo = (k % 10) < 3;
      ew = (k % 10) == 0;
      checks++;
      if (o_out[2] !== eo) begin
        errors++;
        $display("FAIL pwm_d3_out k=%0d got=%b exp=%b", k, o_out[2], eo);
      end
      checks++;
      if (o_wrap[2] !== ew) begin
        errors++;
        $display("FAIL pwm_d3_wrap k=%0d got=%b exp=%b", k, o_wrap[2], ew);
      end
    end
    cfg_write(2'd2, 2'd3, 16'd10, 16'd0);
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (o_out[2] !== 1'b0) begin
        errors++;
        $display("FAIL pwm_d0_out k=%0d got=%b exp=0", k, o_out[2]);
      end
    end
    cfg_write(2'd2, 2'd3, 16'd10, 16'd10);
    for (int k = 1; k <= 12; k++) begin
      step();
      ew = (k % 10) == 0;
      checks++;
      if (o_out[2] !== 1'b1) begin
        errors++;
        $display("FAIL pwm_d10_out k=%0d got=%b exp=1", k, o_out[2]);
      end
      checks++;
      if (o_wrap[2] !== ew) begin
        errors++;
        $display("FAIL pwm_d10_wrap k=%0d got=%b exp=%b", k, o_wrap[2], ew);
      end
    end
    cfg_write(2'd2, 2'd3, 16'd10, 16'd15);
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (o_out[2] !== 1'b1) begin
        errors++;
        $display("FAIL pwm_d15_out k=%0d got=%b exp=1", k, o_out[2]);
      end
    end
  endtask

  // Enable drop, restart, config collision on ch0 and an ignored out-of-range write.
  task automatic test_enable_and_collision();
    logic [2:0] eo, ew;
    cfg_write(2'd2, 2'd3, 16'd10, 16'd3);
    for (int i = 0; i < 3; i++) step();
    enable = 1'b0;
    step();
    checks++;
    if (o_out !== 3'b000) begin
      errors++;
      $display("FAIL endrop_out got=%b exp=%b", o_out, 3'b000);
    end
    checks++;
    if (o_wrap !== 3'b000) begin
      errors++;
      $display("FAIL endrop_wrap got=%b exp=%b", o_wrap, 3'b000);
    end
    enable = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step();
      eo[0] = ((k / 3) % 2) == 1;
      eo[1] = (k % 2) == 0;
      eo[2] = (k % 10) < 3;
      ew[0] = (k % 3) == 0;
      ew[1] = (k % 2) == 0;
      ew[2] = (k % 10) == 0;
      checks++;
      if (o_out !== eo) begin
        errors++;
        $display("FAIL restart_out k=%0d got=%b exp=%b", k, o_out, eo);
      end
      checks++;
      if (o_wrap !== ew) begin
        errors++;
        $display("FAIL restart_wrap k=%0d got=%b exp=%b", k, o_wrap, ew);
      end
    end
    // Edge 12 is a ch0 wrap; the write must win and suppress the toggle.
    cfg_write(2'd0, 2'd1, 16'd5, 16'd0);
    checks++;
    if (o_out !== 3'b110) begin
      errors++;
      $display("FAIL collide_out got=%b exp=%b", o_out, 3'b110);
    end
    checks++;
    if (o_wrap !== 3'b010) begin
      errors++;
      $display("FAIL collide_wrap got=%b exp=%b", o_wrap, 3'b010);
    end
    for (int j = 1; j <= 12; j++) begin
      if (j == 6) begin
        i_cfg_valid  = 1'b1;
        i_cfg_ch     = 2'd3;
        i_cfg_mode   = 2'd0;
        i_cfg_period = 16'd1;
        i_cfg_duty   = 16'd0;
      end
      step();
      i_cfg_valid = 1'b0;
      eo[0] = ((j / 5) % 2) == 1;
      eo[1] = (j % 2) == 0;
      eo[2] = ((12 + j) % 10) < 3;
      ew[0] = (j % 5) == 0;
      ew[1] = (j % 2) == 0;
      ew[2] = ((12 + j) % 10) == 0;
      checks++;
      if (o_out !== eo) begin
        errors++;
        $display("FAIL after_collide_out j=%0d got=%b exp=%b", j, o_out, eo);
      end
      checks++;
      if (o_wrap !== ew) begin
        errors++;
        $display("FAIL after_collide_wrap j=%0d got=%b exp=%b", j, o_wrap, ew);
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [2:0] eo;
    reset_n = 1'b0;
    step();
    checks++;
    if (o_out !== 3'b000) begin
      errors++;
      $display("FAIL midreset_out got=%b exp=%b", o_out, 3'b000);
    end
    checks++;
    if (o_wrap !== 3'b000) begin
      errors++;
      $display("FAIL midreset_wrap got=%b exp=%b", o_wrap, 3'b000);
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if ((o_out | o_wrap) !== 3'b000) begin
        errors++;
        $display("FAIL postreset_idle k=%0d got out=%b wrap=%b exp=000", k, o_out, o_wrap);
      end
    end
    cfg_write(2'd0, 2'd1, 16'd2, 16'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      eo = {2'b00, ((k / 2) % 2) == 1};
      checks++;
      if (o_out !== eo) begin
        errors++;
        $display("FAIL postreset_toggle k=%0d got=%b exp=%b", k, o_out, eo);
      end
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    enable       = 1'b0;
    i_presc_th   = 8'd1;
    i_cfg_valid  = 1'b0;
    i_cfg_ch     = '0;
    i_cfg_mode   = 2'd0;
    i_cfg_period = '0;
    i_cfg_duty   = '0;
    test_reset();
    test_toggle();
    test_prescaler_pulse();
    test_pwm();
    test_enable_and_collision();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multi_ch_blink_gen.md
# multi_ch_blink_gen

Parametrised multi-channel blink/pulse/PWM generator that drives LEDs and GPIO strobes from one system clock. A shared prescaler produces a tick. Each of NUM_CH channels runs its own period counter on that tick, in one of four modes. Per-channel configuration is written at run time through a valid/index port, so the block replaces single-threshold toggle counters.

## Interface
- NUM_CH, 4: number of channels, 1..16
- CNT_W, 32: width of the channel period/duty counters
- PRESC_W, 16: width of the prescaler counter
- CH_W, $clog2(NUM_CH) (min 1): width of the channel index
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low
- enable  in  1  global run; low clears all counters and outputs, keeps configuration
- i_presc_th  in  PRESC_W  prescaler threshold; one tick every i_presc_th cycles (0 treated as 1)
- i_cfg_valid  in  1  configuration write strobe, accepted every cycle it is high
- i_cfg_ch  in  CH_W  target channel; values >= NUM_CH ignored
- i_cfg_mode  in  2  0=OFF, 1=TOGGLE, 2=PULSE, 3=PWM
- i_cfg_period  in  CNT_W  period in ticks (0 treated as 1)
- i_cfg_duty  in  CNT_W  PWM high time in ticks
- o_out  out  NUM_CH  registered channel outputs
- o_wrap  out  NUM_CH  registered one-cycle pulse per channel counter wrap

## Operation
- Reset (reset_n=0 at an edge): prescaler=0, all cnt=0, mode=OFF, period=0, duty=0, o_out=0, o_wrap=0.
- Prescaler:
  - th_eff = max(i_presc_th,1).
  - tick = enable && (presc_cnt == th_eff-1).
  - On tick, presc_cnt goes to 0. Otherwise it increments while enable=1.
  - If presc_cnt > th_eff-1 (threshold lowered), it goes to 0 and tick asserts.
- Channel c, with per_eff = max(period,1):
  - wrap_c = tick && mode!=OFF && cnt >= per_eff-1.
  - On wrap_c, cnt goes to 0. On a tick without wrap_c, cnt increments. Otherwise cnt holds.
- Modes:
  - OFF: cnt held 0, o_out=0, o_wrap=0.
  - TOGGLE: o_out inverts on each wrap_c.
  - PULSE: o_out=1 for exactly the one cycle following the wrap_c edge, 0 otherwise.
  - PWM: o_out <= (cnt_next < duty), so o_out always equals (cnt < duty) for the current cnt. duty=0 gives constant 0. duty >= per_eff gives constant 1.
- o_wrap[c] <= wrap_c in every mode except OFF.
- enable=0 at an edge: presc_cnt, all cnt, o_out and o_wrap go to 0. Mode, period and duty are retained.
- Configuration write (i_cfg_valid=1, i_cfg_ch<NUM_CH):
  - Loads mode, period and duty for that channel.
  - Clears its cnt, o_out and o_wrap at the same edge.
  - Takes priority over a coincident tick or wrap for that channel. Other channels are unaffected.
  - Accepted regardless of enable. Ignored during reset.
- Priority per edge: reset_n=0 > enable=0 > config write > tick/wrap.
- Arithmetic: all compares are unsigned. No wrap-around of cnt past per_eff-1. The prescaler and counters never underflow because of the max(…,1) rule.

## Timing
- Outputs are registered and change one edge after the causing condition. There is no combinational path from inputs to outputs.
- From the first edge with enable=1 (th_eff=1, TOGGLE, per_eff=P): the first o_out rise is visible after edge P. o_out then toggles every P cycles (full period 2P). o_wrap is high in the same cycles o_out changes.
- With prescaler th_eff=T, every period above scales by T. The first tick occurs at the T-th enabled edge.
- After a config write at edge N, the channel restarts from cnt=0. Its first wrap is at edge N + per_eff·th_eff, assuming the prescaler phase is aligned. The prescaler is not reset by config writes.
- PULSE high time is exactly 1 clk cycle, independent of the prescaler.

## Test plan
- Reset/defaults: hold reset_n=0 for 3 cycles, enable=1 → o_out=0 and o_wrap=0. Then write ch0 TOGGLE, period=3, presc_th=1 → o_out[0] rises after the 3rd enabled edge and toggles every 3 cycles. o_wrap[0] pulses each toggle.
- Prescaler + PULSE: presc_th=4, ch1 PULSE, period=2 → o_out[1] is a 1-cycle pulse every 8 cycles. Set presc_th=0 → pulse every 2 cycles. Confirm no stall.
- PWM bounds: ch2 PWM, period=10. duty=3 → o_out[2] high for 3 of every 10 cycles. duty=0 → always 0. duty=10 and duty=15 → always 1. o_wrap[2] pulses every 10 cycles.
- Enable drop mid-period: channels running, drop enable for 1 cycle → all outputs 0 next cycle. Raise enable → outputs restart from cnt=0 with the same config.
- Config collision: write ch0 (period=5) in the same cycle ch0 would wrap → no toggle, cnt=0, o_out[0]=0, next wrap after 5 ticks. ch1 continues unaffected. A write with i_cfg_ch=NUM_CH changes nothing.
- Synchronous reset mid-run: assert reset_n=0 for one edge during PWM → all outputs 0 and configuration cleared (all channels OFF) on the next cycle. Deasserting reset_n has no effect until a new config write.
